// File: rtl/mlp_seq.sv
// mlp_seq: sequential two-layer perceptron (N_IN inputs -> N_HID hidden -> 1 output).
// One shared signed multiplier is time-multiplexed over all products.
// L1 spends N_IN cycles on each hidden neuron, and L2 spends N_HID cycles on the output.
//
// Ports:
//   clk           - rising-edge clock
//   rst           - synchronous active-low reset
//   start         - begin one inference (sampled only in IDLE / DONE)
//   data_in       - N_IN signed features, feature i at [(i+1)*DW-1 -: DW]
//   data_weight_1 - per hidden neuron h: N_IN weights followed by a bias (slice width (N_IN+1)*DW)
//   data_weight_2 - N_HID output weights followed by the output bias
//   data_out      - signed result, held until the next done pulse
//   done          - one-cycle pulse when data_out is updated
//   busy          - high while in L1 or L2
module mlp_seq #(
  parameter int N_IN    = 7,
  parameter int N_HID   = 2,
  parameter int DW      = 8,
  parameter int ACC_W   = 24,
  parameter int FRAC    = 0,
  parameter int RELU_EN = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_IN*DW-1:0]            data_in,
  input  logic [N_HID*(N_IN+1)*DW-1:0]  data_weight_1,
  input  logic [(N_HID+1)*DW-1:0]       data_weight_2,
  output logic [DW-1:0]                 data_out,
  output logic                          done,
  output logic                          busy
);

  localparam int IW  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int HW  = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int W1W = N_HID * (N_IN + 1) * DW;
  localparam int W2W = (N_HID + 1) * DW;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW - 1)) - 1);
  // The bitwise inverse of 2^(DW-1)-1 is -2^(DW-1) in two's complement.
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            in_cnt_q, in_cnt_d;
  logic [HW-1:0]            hid_cnt_q, hid_cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [N_IN*DW-1:0]       x_q, x_d;
  logic [W1W-1:0]           w1_q, w1_d;
  logic [W2W-1:0]           w2_q, w2_d;
  logic signed [DW-1:0]     hid_q [N_HID];
  logic signed [DW-1:0]     hid_d [N_HID];
  logic [DW-1:0]            out_q, out_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] v);
    logic signed [DW-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[DW-1:0];
    else                  r = v[DW-1:0];
    return r;
  endfunction

  // Shared MAC datapath
  logic signed [DW-1:0]     mul_a, mul_b, bias;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  bias_ext, prod_ext, acc_sum, acc_shr, act_val;
  logic signed [DW-1:0]     hid_sat, out_sat;
  logic                     first_term, in_last, hid_last;
  logic [31:0]              w1_base;

  always_comb begin
    in_last  = (in_cnt_q == IW'(N_IN - 1));
    hid_last = (hid_cnt_q == HW'(N_HID - 1));
    w1_base  = 32'(hid_cnt_q) * 32'(N_IN + 1);
    if (state_q == L2) begin
      mul_a      = hid_q[hid_cnt_q];
      mul_b      = w2_q[32'(hid_cnt_q) * DW +: DW];
      bias       = w2_q[N_HID * DW +: DW];
      first_term = (hid_cnt_q == '0);
    end else begin
      mul_a      = x_q[32'(in_cnt_q) * DW +: DW];
      mul_b      = w1_q[(w1_base + 32'(in_cnt_q)) * DW +: DW];
      bias       = w1_q[(w1_base + N_IN) * DW +: DW];
      first_term = (in_cnt_q == '0);
    end
    prod     = mul_a * mul_b;
    prod_ext = {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};
    bias_ext = {{(ACC_W - DW){bias[DW-1]}}, bias} <<< FRAC;
    // The first product of a neuron starts from the bias instead of the running sum.
    acc_sum  = (first_term ? bias_ext : acc_q) + prod_ext;
    acc_shr  = acc_sum >>> FRAC;
    act_val  = ((RELU_EN != 0) && acc_shr[ACC_W-1]) ? '0 : acc_shr;
    hid_sat  = sat_dw(act_val);
    out_sat  = sat_dw(acc_shr);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    hid_cnt_d = hid_cnt_q;
    acc_d     = acc_q;
    x_d       = x_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    hid_d     = hid_q;
    out_d     = out_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          x_d       = data_in;
          w1_d      = data_weight_1;
          w2_d      = data_weight_2;
          in_cnt_d  = '0;
          hid_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = L1;
        end
      end
      L1: begin
        acc_d = acc_sum;
        if (in_last) begin
          hid_d[hid_cnt_q] = hid_sat;
          in_cnt_d         = '0;
          if (hid_last) begin
            hid_cnt_d = '0;
            state_d   = L2;
          end else begin
            hid_cnt_d = hid_cnt_q + 1'b1;
          end
        end else begin
          in_cnt_d = in_cnt_q + 1'b1;
        end
      end
      L2: begin
        acc_d = acc_sum;
        if (hid_last) begin
          out_d     = out_sat;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          hid_cnt_d = '0;
          state_d   = DONE;
        end else begin
          hid_cnt_d = hid_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      hid_cnt_q <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      for (int h = 0; h < N_HID; h++) hid_q[h] <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      hid_cnt_q <= hid_cnt_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      hid_q     <= hid_d;
      out_q     <= out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out = out_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mlp_seq.sv
// tb_mlp_seq: directed bench for mlp_seq. Two instances share all inputs, one with ReLU
// enabled and one with ReLU bypassed. A reference model computes the expected result
// when each inference is captured, and a queue holds it until done is seen.
module tb_mlp_seq;
  localparam int N_IN  = 7;
  localparam int N_HID = 2;
  localparam int DW    = 8;
  localparam int ACC_W = 24;
  localparam int FRAC  = 0;
  localparam int W1W   = N_HID * (N_IN + 1) * DW;
  localparam int W2W   = (N_HID + 1) * DW;
  localparam int LAT   = N_HID * N_IN + N_HID;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [N_IN*DW-1:0] data_in = '0;
  logic [W1W-1:0] data_weight_1 = '0;
  logic [W2W-1:0] data_weight_2 = '0;
  logic signed [DW-1:0] data_out, data_out_nr;
  logic done, busy, done_nr, busy_nr;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_nr_q[$];
  int last_exp = 0;
  int last_exp_nr = 0;
  int edge_cnt = 0;
  int last_done_edge = 0;
  int prev_done_edge = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .DW(DW), .ACC_W(ACC_W), .FRAC(FRAC), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .data_weight_1(data_weight_1), .data_weight_2(data_weight_2),
    .data_out(data_out), .done(done), .busy(busy)
  );

  mlp_seq #(.N_IN(N_IN), .N_HID(N_HID), .DW(DW), .ACC_W(ACC_W), .FRAC(FRAC), .RELU_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .data_weight_1(data_weight_1), .data_weight_2(data_weight_2),
    .data_out(data_out_nr), .done(done_nr), .busy(busy_nr)
  );

  function automatic int clamp(input longint v);
    longint mx = (64'sd1 <<< (DW - 1)) - 1;
    if (v > mx) return int'(mx);
    if (v < -mx - 1) return int'(-mx - 1);
    return int'(v);
  endfunction

  function automatic int model(input logic [N_IN*DW-1:0] x, input logic [W1W-1:0] w1,
                               input logic [W2W-1:0] w2, input bit relu);
    longint acc, s;
    int hid[N_HID];
    logic signed [DW-1:0] a, b;
    for (int h = 0; h < N_HID; h++) begin
      b = w1[(h*(N_IN+1) + N_IN)*DW +: DW];
      acc = longint'(b) <<< FRAC;
      for (int i = 0; i < N_IN; i++) begin
        a = x[i*DW +: DW];
        b = w1[(h*(N_IN+1) + i)*DW +: DW];
        acc += longint'(a) * longint'(b);
      end
      s = acc >>> FRAC;
      if (relu && s < 0) s = 0;
      hid[h] = clamp(s);
    end
    b = w2[N_HID*DW +: DW];
    acc = longint'(b) <<< FRAC;
    for (int h = 0; h < N_HID; h++) begin
      b = w2[h*DW +: DW];
      acc += longint'(hid[h]) * longint'(b);
    end
    return clamp(acc >>> FRAC);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pattern(input int xv, input int w1v, input int b1v, input int w2v, input int b2v);
    for (int i = 0; i < N_IN; i++) data_in[i*DW +: DW] = DW'(xv);
    for (int h = 0; h < N_HID; h++) begin
      for (int i = 0; i < N_IN; i++) data_weight_1[(h*(N_IN+1) + i)*DW +: DW] = DW'(w1v);
      data_weight_1[(h*(N_IN+1) + N_IN)*DW +: DW] = DW'(b1v);
      data_weight_2[h*DW +: DW] = DW'(w2v);
    end
    data_weight_2[N_HID*DW +: DW] = DW'(b2v);
  endtask

  task automatic set_random();
    for (int i = 0; i < N_IN; i++) data_in[i*DW +: DW] = DW'($urandom);
    for (int f = 0; f < N_HID*(N_IN+1); f++) data_weight_1[f*DW +: DW] = DW'($urandom);
    for (int f = 0; f <= N_HID; f++) data_weight_2[f*DW +: DW] = DW'($urandom);
  endtask

  // Raise start for the next edge, record the expected results at the capture edge,
  // and optionally scramble the inputs so that late input changes would show up.
  task automatic start_run(input bit hold);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(data_in, data_weight_1, data_weight_2, 1'b1));
    exp_nr_q.push_back(model(data_in, data_weight_1, data_weight_2, 1'b0));
    #1;
    if (!hold) begin
      start = 1'b0;
      data_in = ~data_in;
      data_weight_1 = ~data_weight_1;
      data_weight_2 = ~data_weight_2;
    end
  endtask

  task automatic wait_done(input string tag, input int cyc0, input int busy0);
    int busy_n;
    bit seen;
    int ev, ev_nr;
    busy_n = busy0;
    seen = 1'b0;
    for (int cyc = cyc0 + 1; cyc <= cyc0 + 40 && !seen; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
        ev_nr = (exp_nr_q.size() > 0) ? exp_nr_q.pop_front() : 9999;
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_busy_cycles"}, busy_n, LAT);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_data_out"}, data_out, ev);
        check({tag, "_done_norelu"}, done_nr, 1);
        check({tag, "_data_out_norelu"}, data_out_nr, ev_nr);
        last_exp = ev;
        last_exp_nr = ev_nr;
        prev_done_edge = last_done_edge;
        last_done_edge = edge_cnt;
      end else if (busy) begin
        busy_n++;
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic finish_idle(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_data_out_hold"}, data_out, last_exp);
    check({tag, "_data_out_hold_norelu"}, data_out_nr, last_exp_nr);
    $display("txn %s: data_out=%0d data_out_norelu=%0d", tag, data_out, data_out_nr);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int n;
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (done || done_nr) n++;
    end
    check({tag, "_no_extra_done"}, n, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);

    // All ones: start on the first edge with reset released
    set_pattern(1, 1, 0, 1, 0);
    start_run(1'b0);
    check("rst_release_start_busy", busy, 1);
    wait_done("ones", 0, 1);
    check("ones_expected_14", data_out, 14);
    finish_idle("ones");

    // Positive saturation of hidden neurons and of the output
    set_pattern(127, 127, 0, 1, 0);
    start_run(1'b0);
    wait_done("sat_pos", 0, 1);
    check("sat_pos_expected_127", data_out, 127);
    finish_idle("sat_pos");

    // ReLU on vs off
    set_pattern(1, -1, 0, 1, 5);
    start_run(1'b0);
    wait_done("relu", 0, 1);
    check("relu_on_expected_5", data_out, 5);
    check("relu_off_expected_m9", data_out_nr, -9);
    finish_idle("relu");

    // Negative saturation without ReLU
    set_pattern(127, -128, 0, 127, 0);
    start_run(1'b0);
    wait_done("sat_neg", 0, 1);
    check("sat_neg_norelu_expected_m128", data_out_nr, -128);
    finish_idle("sat_neg");

    // Second start pulse at edge 5 is ignored
    set_pattern(3, -2, 4, 2, -3);
    start_run(1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_start_still_busy", busy, 1);
    wait_done("busy_start", 5, 6);
    finish_idle("busy_start");
    count_done("busy_start", 20);

    // Reset mid-run at edge 8
    set_pattern(1, 1, 0, 1, 0);
    start_run(1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_data_out", data_out, 0);
    check("midreset_data_out_norelu", data_out_nr, 0);
    rst = 1'b1;
    exp_q.delete();
    exp_nr_q.delete();
    count_done("midreset", 20);
    set_pattern(2, 1, -1, 1, 1);
    start_run(1'b0);
    wait_done("after_reset", 0, 1);
    finish_idle("after_reset");

    // Random patterns
    for (int r = 0; r < 3; r++) begin
      set_random();
      start_run(1'b0);
      wait_done("random", 0, 1);
      finish_idle("random");
    end

    // Back-to-back with start held high and new data after each done
    set_pattern(2, 3, 1, -1, 4);
    start_run(1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_done("b2b", 0, 1);
      $display("txn b2b[%0d]: data_out=%0d", k, data_out);
      if (k > 0) check("b2b_period", last_done_edge - prev_done_edge, LAT + 1);
      if (k < 3) begin
        set_random();
        @(posedge clk);
        exp_q.push_back(model(data_in, data_weight_1, data_weight_2, 1'b1));
        exp_nr_q.push_back(model(data_in, data_weight_1, data_weight_2, 1'b0));
        #1;
        check("b2b_capture_busy", busy, 1);
        check("b2b_capture_done_low", done, 0);
      end
    end
    start = 1'b0;
    finish_idle("b2b_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mlp_seq.md
MLP_SEQ -- requirements
Module: mlp_seq

Interface
REQ-001 SHALL have parameter N_IN, default 7: number of input features.
REQ-002 SHALL have parameter N_HID, default 2: number of hidden neurons.
REQ-003 SHALL have parameter DW, default 8: signed two's-complement width of data, weights, biases and output.
REQ-004 SHALL have parameter ACC_W, default 24: signed accumulator width, required to be >= 2*DW + clog2(N_IN+1).
REQ-005 SHALL have parameter FRAC, default 0: fixed-point fraction bits used for the bias shift and the result rescale.
REQ-006 SHALL have parameter RELU_EN, default 1: 1 applies ReLU to hidden neurons, 0 bypasses it.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port start, input, 1 bit: request to begin one inference.
REQ-010 SHALL have port data_in, input, N_IN*DW bits: feature i at bits [(i+1)*DW-1 -: DW].
REQ-011 SHALL have port data_weight_1, input, N_HID*(N_IN+1)*DW bits: neuron h occupies slice h of width (N_IN+1)*DW, with weight i at field i and bias at field N_IN.
REQ-012 SHALL have port data_weight_2, input, (N_HID+1)*DW bits: weight h at field h and bias at field N_HID.
REQ-013 SHALL have port data_out, output, DW bits: signed inference result.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse marking data_out as newly valid.
REQ-015 SHALL have port busy, output, 1 bit: high while a computation is in progress.

Function
REQ-016 SHALL implement the FSM states IDLE, L1, L2 and DONE.
REQ-017 SHALL sample start only in IDLE or DONE; start=1 at that edge SHALL capture data_in, data_weight_1 and data_weight_2 into internal registers and move the FSM to L1.
REQ-018 SHALL compute from the captured registers only; input changes after the capture edge SHALL have no effect on the current inference.
REQ-019 SHALL spend N_IN cycles per hidden neuron in L1 (one multiply per cycle), processing neurons h=0..N_HID-1 in order; the first cycle of each neuron SHALL load acc = (sign-extended bias << FRAC) + x0*w0.
REQ-020 SHALL, on the last cycle of each neuron, write hidden[h] = sat_DW(act(acc_final >>> FRAC)), where act is ReLU when RELU_EN=1 and identity otherwise.
REQ-021 SHALL use signed products and an arithmetic right shift; sat_DW SHALL clamp to [-2^(DW-1), 2^(DW-1)-1].
REQ-022 SHALL spend N_HID cycles in L2 computing (bias2 << FRAC) + sum(hidden[h]*w2[h]) in the same way; on its last cycle it SHALL register data_out = sat_DW(acc >>> FRAC), with no ReLU applied.
REQ-023 SHALL register data_out at edge N_HID*N_IN + N_HID after the start-sampling edge (edge 16 with default parameters), set done=1 at that same edge, and enter DONE.
REQ-024 SHALL hold done high for exactly one cycle; DONE SHALL return to IDLE unless start=1, in which case it SHALL go directly to L1, giving a back-to-back period of N_HID*N_IN + N_HID + 1 cycles.
REQ-025 SHALL drive busy=1 exactly while the FSM is in L1 or L2.
REQ-026 SHALL ignore start while in L1 or L2, with no queuing.
REQ-027 SHALL hold data_out until the next done pulse.

Reset
REQ-028 SHALL, when rst=0 at a rising edge, in any state including mid-computation, set the FSM to IDLE, data_out=0, done=0 and busy=0, and clear the accumulator, counters and hidden registers.
REQ-029 SHALL take priority for rst over start at the same edge; a start asserted on the first edge with rst=1 SHALL be accepted.

Verification
REQ-030 SHALL cover this scenario with defaults: all x=1, all w1=1, all biases=0, w2={1,1} -> hidden=7,7; data_out=14; done at edge 16; busy high for 16 cycles.
REQ-031 SHALL cover saturation: all x=127, all w1=127, w2={1,1}, biases 0 -> hidden clamped to 127; data_out=127.
REQ-032 SHALL cover ReLU: x=1, w1=-1, w2={1,1}, bias2=5 -> with RELU_EN=1, data_out=5; with RELU_EN=0, hidden=-7 and data_out=-9 (0xF7).
REQ-033 SHALL cover busy-start: a second start pulse at edge 5 -> ignored; exactly one done pulse; result equal to the single-start run.
REQ-034 SHALL cover reset mid-run: rst=0 at edge 8 -> next cycle busy=0, done=0, data_out=0; no done pulse follows; a fresh start then gives the correct result at edge 16.
REQ-035 SHALL cover back-to-back operation: start held at 1 with new data_in applied after each done -> done every 17 cycles, with each data_out matching its own captured inputs.
